backtrack_unwinder: RTL and testbench
=====================================

# backtrack_unwinder

Initiator and consumer for the trail manager's backtrack interface. It accepts a backtrack request from the solver core and issues a single-cycle backtrack command with the target level to the trail manager. It then drains the popped-entry stream, turning each popped assignment into a clear strobe for the assignment table and a phase-save write, and reports completion with pop statistics. It sits between the solver core FSM and the trail manager.

## Interface
- MAX_VARS, 16, size of variable index space; legal variable IDs are 1..MAX_VARS-1
- DRAIN_TIMEOUT, MAX_VARS+4, maximum consecutive DRAIN cycles without tm_backtrack_done before abort
- clk  in  1  single clock; all logic is rising-edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  backtrack request from core
- req_level  in  16  target decision level
- req_ready  out  1  high only in IDLE; a request is accepted on an edge where req_valid && req_ready
- clear_all  in  1  synchronous abort, returns to IDLE
- tm_backtrack_en  out  1  one-cycle command pulse to trail manager
- tm_backtrack_to_level  out  16  target level, held stable from ISSUE until IDLE
- tm_backtrack_valid  in  1  popped entry valid this cycle
- tm_backtrack_var  in  32  popped variable
- tm_backtrack_value  in  1  popped value
- tm_backtrack_is_decision  in  1  popped entry was a decision
- tm_backtrack_done  in  1  trail manager finished popping
- clr_valid  out  1  clear strobe to assignment table
- clr_var  out  32  variable to clear
- phase_we  out  1  phase-save write enable
- phase_var  out  32  phase-save variable
- phase_value  out  1  saved phase, equal to the popped value
- done  out  1  one-cycle completion pulse
- popped_count  out  16  entries popped in last or current backtrack
- decisions_popped  out  16  decision entries popped
- err_var_range  out  1  sticky; an out-of-range var was popped
- err_timeout  out  1  sticky; drain timed out

## Operation
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
- **IDLE**
  - On an accepted request, latch req_level into tm_backtrack_to_level.
  - Zero popped_count, decisions_popped and the timeout counter.
  - Go to ISSUE.
- **ISSUE**
  - tm_backtrack_en = 1 for exactly this one cycle.
  - Go to DRAIN.
- **DRAIN**, on each edge with tm_backtrack_valid = 1:
  - popped_count++, saturating at 16'hFFFF.
  - If is_decision, decisions_popped++, saturating at 16'hFFFF.
  - If 1 ≤ var < MAX_VARS, then in the next cycle: clr_valid = 1, clr_var = var, phase_we = 1, phase_var = var, phase_value = value.
  - Otherwise set err_var_range; no clear or phase strobe is issued, but the entry is still counted.
- **DRAIN**, on tm_backtrack_done:
  - Go to FINISH.
  - If tm_backtrack_valid is also high on that edge, process the entry normally.
  - Entries arriving after done are ignored.
- **DRAIN** timeout counter:
  - Increments every DRAIN cycle in which tm_backtrack_done = 0.
  - On reaching DRAIN_TIMEOUT, set err_timeout and go to FINISH.
- **FINISH**: done = 1 for one cycle, then go to IDLE. Counters hold their values until the next accepted request.
- **clear_all** (highest priority after reset):
  - Next state is IDLE.
  - Counters are zeroed.
  - No done pulse.
  - Strobes are deasserted next cycle.
  - Error flags are cleared.
- req_valid while not in IDLE is ignored; the request is not queued.
- Error flags clear only on reset_n or clear_all.

## Timing
- Reset values:
  - state = IDLE, so req_ready = 1.
  - All other outputs = 0, including tm_backtrack_to_level, counters, strobes, clr_var/phase_var/phase_value and error flags.
- Request accepted at edge N → tm_backtrack_en high in cycle N..N+1 (registered) → DRAIN from edge N+1.
- Entry sampled at edge M → clr/phase strobes high for exactly cycle M..M+1.
- Back-to-back entries produce back-to-back strobes; no bubbles and no backpressure.
- Counters are visible one cycle after the sampling edge.
- done sampled at edge D → FINISH in cycle D..D+1, done high there → req_ready high from edge D+1.
- A final entry popped together with done produces its clr strobe in the same cycle as the done pulse.
- Minimum turnaround, request to next req_ready: 3 cycles (ISSUE, DRAIN, FINISH) when done arrives in the first DRAIN cycle.
- reset_n asserted mid-operation → immediate return to reset values; no done pulse.

## Test plan
- Reset: hold reset_n low 2 cycles → req_ready = 1; tm_backtrack_en, done, clr_valid, popped_count, err_* = 0; tm_backtrack_to_level = 0.
- Single pop: req_level = 1 → tm_backtrack_en high exactly 1 cycle with level 1. Then pop (var 3, value 1, decision) together with done → clr_var = 3, phase_value = 1, done in the same cycle, popped_count = 1, decisions_popped = 1.
- Burst: request level 0; pop vars 3, 2, 1 on consecutive cycles with done on the var-1 edge (2 decisions) → three consecutive clr strobes 3, 2, 1; popped_count = 3, decisions_popped = 2, single done pulse.
- Empty and busy: done with no valid → done, popped_count = 0. A req_valid pulse during DRAIN produces no second tm_backtrack_en.
- Range: pop var 0 and var 16 (MAX_VARS = 16) → err_var_range = 1, no clr_valid, popped_count = 2. err_var_range stays set across the next backtrack until clear_all.
- Abort and timeout:
  - No done for 20 cycles → err_timeout = 1 and a done pulse on the 21st cycle.
  - Separately, clear_all mid-DRAIN → IDLE next cycle, no done, counters = 0.

Source files
------------

// File: rtl/backtrack_unwinder.sv
// Backtrack unwinder: issues a backtrack command to the trail manager, drains the
// popped-entry stream into clear/phase-save strobes and reports pop statistics.
//
// state  | meaning
// IDLE   | waiting for a backtrack request; req_ready high
// ISSUE  | tm_backtrack_en pulse with the latched target level
// DRAIN  | consuming popped entries until done or timeout
// FINISH | one-cycle done pulse, then back to IDLE
module backtrack_unwinder #(
  parameter int MAX_VARS      = 16,
  parameter int DRAIN_TIMEOUT = MAX_VARS + 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic [15:0] req_level,
  output logic        req_ready,
  input  logic        clear_all,
  output logic        tm_backtrack_en,
  output logic [15:0] tm_backtrack_to_level,
  input  logic        tm_backtrack_valid,
  input  logic [31:0] tm_backtrack_var,
  input  logic        tm_backtrack_value,
  input  logic        tm_backtrack_is_decision,
  input  logic        tm_backtrack_done,
  output logic        clr_valid,
  output logic [31:0] clr_var,
  output logic        phase_we,
  output logic [31:0] phase_var,
  output logic        phase_value,
  output logic        done,
  output logic [15:0] popped_count,
  output logic [15:0] decisions_popped,
  output logic        err_var_range,
  output logic        err_timeout
);

  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t        state_q, state_d;
  logic          req_ready_q, req_ready_d;
  logic          en_q, en_d;
  logic [15:0]   level_q, level_d;
  logic          clr_valid_q, clr_valid_d;
  logic [31:0]   clr_var_q, clr_var_d;
  logic          phase_value_q, phase_value_d;
  logic          done_q, done_d;
  logic [15:0]   popped_q, popped_d;
  logic [15:0]   dec_q, dec_d;
  logic          err_range_q, err_range_d;
  logic          err_to_q, err_to_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          var_ok;

  assign var_ok = (tm_backtrack_var != 32'd0) && (tm_backtrack_var < 32'(MAX_VARS));

  always_comb begin
    state_d       = state_q;
    en_d          = 1'b0;
    level_d       = level_q;
    clr_valid_d   = 1'b0;
    clr_var_d     = clr_var_q;
    phase_value_d = phase_value_q;
    done_d        = 1'b0;
    popped_d      = popped_q;
    dec_d         = dec_q;
    err_range_d   = err_range_q;
    err_to_d      = err_to_q;
    timer_d       = timer_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          level_d  = req_level;
          popped_d = '0;
          dec_d    = '0;
          timer_d  = TW'(DRAIN_TIMEOUT);
          en_d     = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = DRAIN;
      DRAIN: begin
        if (tm_backtrack_valid) begin
          if (popped_q != 16'hFFFF) popped_d = popped_q + 16'd1;
          if (tm_backtrack_is_decision && dec_q != 16'hFFFF) dec_d = dec_q + 16'd1;
          if (var_ok) begin
            clr_valid_d   = 1'b1;
            clr_var_d     = tm_backtrack_var;
            phase_value_d = tm_backtrack_value;
          end else begin
            err_range_d = 1'b1;
          end
        end
        // Timer counts down only on cycles without done; terminal count aborts the drain.
        if (tm_backtrack_done) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else if (timer_q <= TW'(1)) begin
          err_to_d = 1'b1;
          state_d  = FINISH;
          done_d   = 1'b1;
          timer_d  = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (clear_all) begin
      state_d     = IDLE;
      en_d        = 1'b0;
      clr_valid_d = 1'b0;
      done_d      = 1'b0;
      popped_d    = '0;
      dec_d       = '0;
      timer_d     = '0;
      err_range_d = 1'b0;
      err_to_d    = 1'b0;
    end

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b1;
      en_q          <= 1'b0;
      level_q       <= '0;
      clr_valid_q   <= 1'b0;
      clr_var_q     <= '0;
      phase_value_q <= 1'b0;
      done_q        <= 1'b0;
      popped_q      <= '0;
      dec_q         <= '0;
      err_range_q   <= 1'b0;
      err_to_q      <= 1'b0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      en_q          <= en_d;
      level_q       <= level_d;
      clr_valid_q   <= clr_valid_d;
      clr_var_q     <= clr_var_d;
      phase_value_q <= phase_value_d;
      done_q        <= done_d;
      popped_q      <= popped_d;
      dec_q         <= dec_d;
      err_range_q   <= err_range_d;
      err_to_q      <= err_to_d;
      timer_q       <= timer_d;
    end
  end

  // The phase-save port mirrors the clear strobe one-for-one.
  assign req_ready             = req_ready_q;
  assign tm_backtrack_en       = en_q;
  assign tm_backtrack_to_level = level_q;
  assign clr_valid             = clr_valid_q;
  assign clr_var               = clr_var_q;
  assign phase_we              = clr_valid_q;
  assign phase_var             = clr_var_q;
  assign phase_value           = phase_value_q;
  assign done                  = done_q;
  assign popped_count          = popped_q;
  assign decisions_popped      = dec_q;
  assign err_var_range         = err_range_q;
  assign err_timeout           = err_to_q;

endmodule

// File: tb/tb_backtrack_unwinder.sv
// Directed bench for backtrack_unwinder: clear/phase strobes checked against a
// scoreboard of expected (cycle, var, value) entries; status checked inline.
module tb_backtrack_unwinder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic [15:0] req_level;
  logic        req_ready;
  logic        clear_all;
  logic        tm_backtrack_en;
  logic [15:0] tm_backtrack_to_level;
  logic        tm_backtrack_valid;
  logic [31:0] tm_backtrack_var;
  logic        tm_backtrack_value;
  logic        tm_backtrack_is_decision;
  logic        tm_backtrack_done;
  logic        clr_valid;
  logic [31:0] clr_var;
  logic        phase_we;
  logic [31:0] phase_var;
  logic        phase_value;
  logic        done;
  logic [15:0] popped_count;
  logic [15:0] decisions_popped;
  logic        err_var_range;
  logic        err_timeout;

  backtrack_unwinder #(.MAX_VARS(16), .DRAIN_TIMEOUT(20)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_level(req_level), .req_ready(req_ready),
    .clear_all(clear_all),
    .tm_backtrack_en(tm_backtrack_en), .tm_backtrack_to_level(tm_backtrack_to_level),
    .tm_backtrack_valid(tm_backtrack_valid), .tm_backtrack_var(tm_backtrack_var),
    .tm_backtrack_value(tm_backtrack_value), .tm_backtrack_is_decision(tm_backtrack_is_decision),
    .tm_backtrack_done(tm_backtrack_done),
    .clr_valid(clr_valid), .clr_var(clr_var),
    .phase_we(phase_we), .phase_var(phase_var), .phase_value(phase_value),
    .done(done), .popped_count(popped_count), .decisions_popped(decisions_popped),
    .err_var_range(err_var_range), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          cyc;
    logic [31:0] v;
    logic        val;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   en_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(posedge clk) cyc++;

  // Strobe monitor: every clear strobe must match the oldest expected entry, on its cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (done) done_cnt++;
      if (tm_backtrack_en) en_cnt++;
      if (clr_valid) begin
        if (exp_q.size() == 0) begin
          check("clr_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("clr_cycle", cyc, e.cyc);
          check("clr_var", clr_var, e.v);
          check("phase_we", {31'd0, phase_we}, 32'd1);
          check("phase_var", phase_var, e.v);
          check("phase_value", {31'd0, phase_value}, {31'd0, e.val});
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0;
    tm_backtrack_valid = 1'b0;
    tm_backtrack_var = '0;
    tm_backtrack_value = 1'b0;
    tm_backtrack_is_decision = 1'b0;
    tm_backtrack_done = 1'b0;
  endtask

  // Leaves the DUT in its first DRAIN cycle.
  task automatic request(input logic [15:0] lvl);
    req_valid = 1'b1;
    req_level = lvl;
    step();
    check("en_pulse", {31'd0, tm_backtrack_en}, 32'd1);
    check("to_level", {16'd0, tm_backtrack_to_level}, {16'd0, lvl});
    check("ready_busy", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b0;
    step();
    check("en_one_cycle", {31'd0, tm_backtrack_en}, 32'd0);
  endtask

  task automatic pop(input logic [31:0] v, input logic val, input logic dec, input logic dn);
    tm_backtrack_valid = 1'b1;
    tm_backtrack_var = v;
    tm_backtrack_value = val;
    tm_backtrack_is_decision = dec;
    tm_backtrack_done = dn;
    if (v >= 32'd1 && v < 32'd16) exp_q.push_back('{cyc: cyc + 1, v: v, val: val});
    step();
    idle_inputs();
  endtask

  initial begin
    int d0;
    reset_n = 1'b0;
    clear_all = 1'b0;
    req_level = '0;
    idle_inputs();
    step();
    step();
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_en", {31'd0, tm_backtrack_en}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_clr", {31'd0, clr_valid}, 32'd0);
    check("rst_popped", {16'd0, popped_count}, 32'd0);
    check("rst_errs", {30'd0, err_var_range, err_timeout}, 32'd0);
    check("rst_level", {16'd0, tm_backtrack_to_level}, 32'd0);
    reset_n = 1'b1;
    step();

    // Single pop together with done
    request(16'd1);
    pop(32'd3, 1'b1, 1'b1, 1'b1);
    check("single_done", {31'd0, done}, 32'd1);
    check("single_popped", {16'd0, popped_count}, 32'd1);
    check("single_dec", {16'd0, decisions_popped}, 32'd1);
    step();
    check("single_done_off", {31'd0, done}, 32'd0);
    check("single_ready", {31'd0, req_ready}, 32'd1);

    // Burst of three
    d0 = done_cnt;
    request(16'd0);
    pop(32'd3, 1'b1, 1'b1, 1'b0);
    pop(32'd2, 1'b0, 1'b0, 1'b0);
    pop(32'd1, 1'b1, 1'b1, 1'b1);
    check("burst_done", {31'd0, done}, 32'd1);
    check("burst_popped", {16'd0, popped_count}, 32'd3);
    check("burst_dec", {16'd0, decisions_popped}, 32'd2);
    step();
    step();
    check("burst_one_done", done_cnt - d0, 32'd1);

    // Empty drain, and a request while busy
    request(16'd5);
    req_valid = 1'b1;
    step();
    step();
    req_valid = 1'b0;
    tm_backtrack_done = 1'b1;
    step();
    idle_inputs();
    check("empty_done", {31'd0, done}, 32'd1);
    check("empty_popped", {16'd0, popped_count}, 32'd0);
    check("busy_no_en", en_cnt, 32'd3);
    step();

    // Out-of-range vars
    request(16'd2);
    pop(32'd0, 1'b1, 1'b0, 1'b0);
    pop(32'd16, 1'b0, 1'b0, 1'b1);
    check("range_err", {31'd0, err_var_range}, 32'd1);
    check("range_popped", {16'd0, popped_count}, 32'd2);
    step();
    request(16'd1);
    pop(32'd4, 1'b0, 1'b0, 1'b1);
    check("range_sticky", {31'd0, err_var_range}, 32'd1);
    check("range_popped2", {16'd0, popped_count}, 32'd1);
    step();
    clear_all = 1'b1;
    step();
    clear_all = 1'b0;
    check("range_cleared", {31'd0, err_var_range}, 32'd0);

    // Drain timeout after 20 cycles without done
    request(16'd3);
    for (int i = 0; i < 19; i++) step();
    check("to_not_yet", {30'd0, err_timeout, done}, 32'd0);
    step();
    check("to_err", {31'd0, err_timeout}, 32'd1);
    check("to_done", {31'd0, done}, 32'd1);
    step();
    check("to_ready", {31'd0, req_ready}, 32'd1);

    // clear_all mid-DRAIN
    d0 = done_cnt;
    request(16'd4);
    pop(32'd5, 1'b1, 1'b1, 1'b0);
    check("abort_popped_pre", {16'd0, popped_count}, 32'd1);
    clear_all = 1'b1;
    step();
    clear_all = 1'b0;
    check("abort_ready", {31'd0, req_ready}, 32'd1);
    check("abort_counters", {popped_count, decisions_popped}, 32'd0);
    check("abort_flags", {29'd0, err_timeout, clr_valid, done}, 32'd0);
    step();
    check("abort_no_done", done_cnt - d0, 32'd0);

    // Asynchronous reset mid-operation
    request(16'd7);
    #1 reset_n = 1'b0;
    #1;
    check("arst_level", {16'd0, tm_backtrack_to_level}, 32'd0);
    check("arst_ready", {31'd0, req_ready}, 32'd1);
    step();
    reset_n = 1'b1;
    step();

    check("total_done", done_cnt, 32'd6);
    check("total_en", en_cnt, 32'd8);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
